// File: rtl/sipo_rx.sv
// ---------------------------------------------------------------------------
// sipo_rx : serial-in parallel-out receiver
//
// Collects WIDTH serial bits (qualified by sin_en_i) into a shift register and
// hands each completed word to a one-entry holding register with a
// valid/ready handshake. A word that completes while the holding register
// is still occupied and not being consumed is dropped, and overrun_o is set
// until the next clear.
//
// Ports
//   clk_i       in   1      rising-edge clock
//   clr_i       in   1      synchronous active-high clear of all state
//   sin_i       in   1      serial data bit
//   sin_en_i    in   1      sample sin_i on this edge
//   sync_i      in   1      discard partial word, restart bit count
//   q_o         out  WIDTH  received word (holding register)
//   q_valid_o   out  1      q_o holds an unconsumed word
//   q_ready_i   in   1      consumer accepts q_o when q_valid_o & q_ready_i
//   bit_cnt_o   out  CW     bits collected in current partial word
//   overrun_o   out  1      sticky: a completed word was dropped
// ---------------------------------------------------------------------------
module sipo_rx #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b0,
    localparam int unsigned CW       = $clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             sin_i,
    input  logic             sin_en_i,
    input  logic             sync_i,
    output logic [WIDTH-1:0] q_o,
    output logic             q_valid_o,
    input  logic             q_ready_i,
    output logic [CW-1:0]    bit_cnt_o,
    output logic             overrun_o
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] shift_nxt;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [0:0]       state_q, state_d;
    logic             ovr_q, ovr_d;
    logic             sample;
    logic             complete;

    // sync wins over sin_en: no bit is taken on a realign edge.
    assign sample   = sin_en_i & ~sync_i;
    assign complete = sample & (cnt_q == CW'(WIDTH - 1));

    // shift_nxt already includes the bit sampled this edge, so it is the
    // completed word on the completion edge.
    generate
        if (MSB_FIRST) begin : g_msb
            assign shift_nxt = {sreg_q[WIDTH-2:0], sin_i};
        end else begin : g_lsb
            assign shift_nxt = {sin_i, sreg_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        q_d     = q_q;
        ovr_d   = ovr_q;

        if (sync_i) begin
            sreg_d = '0;
            cnt_d  = '0;
        end else if (sample) begin
            if (complete) begin
                sreg_d = '0;
                cnt_d  = '0;
            end else begin
                sreg_d = shift_nxt;
                cnt_d  = cnt_q + CW'(1);
            end
        end

        case (state_q)
            ST_EMPTY: begin
                if (complete) begin
                    state_d = ST_FULL;
                    q_d     = shift_nxt;
                end
            end
            ST_FULL: begin
                if (complete) begin
                    // Consumer takes the old word on the same edge: refill.
                    if (q_ready_i) q_d   = shift_nxt;
                    else           ovr_d = 1'b1;
                end else if (q_ready_i) begin
                    state_d = ST_EMPTY;   // q keeps its last value
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            sreg_q  <= '0;
            cnt_q   <= '0;
            state_q <= ST_EMPTY;
            q_q     <= '0;
            ovr_q   <= 1'b0;
        end else begin
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            q_q     <= q_d;
            ovr_q   <= ovr_d;
        end
    end

    assign q_o       = q_q;
    assign q_valid_o = (state_q == ST_FULL);
    assign bit_cnt_o = cnt_q;
    assign overrun_o = ovr_q;

endmodule

// File: tb/tb_sipo_rx.sv
module tb_sipo_rx;
    localparam int W  = 4;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          clr = 1'b0, sin = 1'b0, sin_en = 1'b0, sync = 1'b0, q_ready = 1'b1;
    logic [W-1:0]  q_a, q_b;
    logic          v_a, v_b, ov_a, ov_b;
    logic [CW-1:0] cnt_a, cnt_b;

    int checks = 0, failures = 0;

    // Reference model state
    int           m_cnt = 0;
    logic [W-1:0] m_bits = '0;
    bit           m_full = 0, m_ovr = 0;
    logic [W-1:0] sb0[$];   // expected words, LSB-first instance
    logic [W-1:0] sb1[$];   // expected words, MSB-first instance

    always #5 clk = ~clk;

    sipo_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk_i(clk), .clr_i(clr), .sin_i(sin), .sin_en_i(sin_en), .sync_i(sync),
        .q_o(q_a), .q_valid_o(v_a), .q_ready_i(q_ready), .bit_cnt_o(cnt_a), .overrun_o(ov_a));

    sipo_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk_i(clk), .clr_i(clr), .sin_i(sin), .sin_en_i(sin_en), .sync_i(sync),
        .q_o(q_b), .q_valid_o(v_b), .q_ready_i(q_ready), .bit_cnt_o(cnt_b), .overrun_o(ov_b));

    // Advance the model with the inputs about to be sampled, then take the edge.
    task automatic tick();
        bit samp, comp;
        logic [W-1:0] w0, w1;
        samp = sin_en && !sync;
        comp = samp && (m_cnt == W - 1);
        if (clr) begin
            m_cnt = 0; m_full = 0; m_ovr = 0;
            sb0.delete(); sb1.delete();
        end else begin
            if (sync) m_cnt = 0;
            else if (samp) begin
                m_bits[m_cnt] = sin;
                if (comp) begin
                    for (int i = 0; i < W; i++) begin
                        w0[i]       = m_bits[i];
                        w1[W-1-i]   = m_bits[i];
                    end
                    if (!m_full || q_ready) begin
                        sb0.push_back(w0); sb1.push_back(w1);
                    end else m_ovr = 1;
                    m_full = 1;
                    m_cnt  = 0;
                end else m_cnt++;
            end
            if (!comp && m_full && q_ready) m_full = 0;
        end
        @(posedge clk); #1;
    endtask

    task automatic send_bit(input logic b);
        sin = b; sin_en = 1'b1;
        tick();
        sin_en = 1'b0; sin = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] bits);   // bits[0] sent first
        for (int i = 0; i < W; i++) send_bit(bits[i]);
    endtask

    task automatic test_reset();
        clr = 1'b1; sin_en = 1'b1; sin = 1'b1;
        tick();
        clr = 1'b0; sin_en = 1'b0; sin = 1'b0;
        checks++; if ({q_a, q_b} !== '0) begin failures++; $display("FAIL reset_q got=%h/%h exp=0/0", q_a, q_b); end
        checks++; if ({v_a, v_b, ov_a, ov_b} !== 4'b0) begin failures++; $display("FAIL reset_flags got v=%b%b ov=%b%b exp=0", v_a, v_b, ov_a, ov_b); end
        checks++; if (cnt_a !== '0 || cnt_b !== '0) begin failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0", cnt_a, cnt_b); end
    endtask

    task automatic test_basic();
        logic [W-1:0] e0, e1;
        q_ready = 1'b1;
        send_word(4'b1011);   // sin = 1,1,0,1
        checks++; if (v_a !== 1'b1 || v_b !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b%b exp=11", v_a, v_b); end
        if (sb0.size() == 0) begin checks++; failures++; $display("FAIL basic_sb empty scoreboard got=0 exp=1"); end
        else begin
            e0 = sb0.pop_front(); e1 = sb1.pop_front();
            checks++; if (q_a !== e0 || q_a !== 4'hB) begin failures++; $display("FAIL basic_lsb got=%h exp=%h", q_a, e0); end
            checks++; if (q_b !== e1 || q_b !== 4'hD) begin failures++; $display("FAIL basic_msb got=%h exp=%h", q_b, e1); end
        end
        tick();
        checks++; if (v_a !== 1'b0 || v_b !== 1'b0) begin failures++; $display("FAIL basic_drain got=%b%b exp=00", v_a, v_b); end
        checks++; if (q_a !== 4'hB) begin failures++; $display("FAIL basic_hold got=%h exp=b", q_a); end
    endtask

    task automatic test_enable_gating();
        logic [W-1:0] bits, e0;
        bits = 4'b0110;       // sin = 0,1,1,0
        for (int i = 0; i < W; i++) begin
            send_bit(bits[i]);
            checks++; if (cnt_a !== CW'((i + 1) % W) || cnt_a !== CW'(m_cnt)) begin failures++; $display("FAIL en_cnt%0d got=%0d exp=%0d", i, cnt_a, (i + 1) % W); end
            if (i < W - 1) begin
                tick();       // sin_en low: count must hold
                checks++; if (cnt_a !== CW'(i + 1)) begin failures++; $display("FAIL en_hold%0d got=%0d exp=%0d", i, cnt_a, i + 1); end
            end
        end
        if (sb0.size() == 0) begin checks++; failures++; $display("FAIL en_sb empty scoreboard got=0 exp=1"); end
        else begin
            e0 = sb0.pop_front(); void'(sb1.pop_front());
            checks++; if (v_a !== 1'b1 || q_a !== e0 || q_a !== 4'h6) begin failures++; $display("FAIL en_word got=%h v=%b exp=%h v=1", q_a, v_a, e0); end
        end
        tick();
    endtask

    task automatic test_overrun();
        q_ready = 1'b0;
        send_word(4'h3);
        checks++; if (v_a !== 1'b1 || ov_a !== 1'b0 || sb0.size() != 1 || q_a !== sb0[0]) begin
            failures++; $display("FAIL ovr_first got=%h v=%b ov=%b exp=3 v=1 ov=0", q_a, v_a, ov_a); end
        send_word(4'h5);
        checks++; if (q_a !== 4'h3 || v_a !== 1'b1) begin failures++; $display("FAIL ovr_hold got=%h v=%b exp=3 v=1", q_a, v_a); end
        checks++; if (ov_a !== m_ovr || ov_a !== 1'b1 || ov_b !== 1'b1) begin failures++; $display("FAIL ovr_flag got=%b%b exp=11", ov_a, ov_b); end
        checks++; if (q_b !== 4'hC) begin failures++; $display("FAIL ovr_msb_hold got=%h exp=c", q_b); end
        if (sb0.size() != 0) begin void'(sb0.pop_front()); void'(sb1.pop_front()); end
        q_ready = 1'b1;
        tick();
        checks++; if (v_a !== 1'b0 || sb0.size() != 0 || ov_a !== 1'b1) begin
            failures++; $display("FAIL ovr_drain got v=%b ov=%b sb=%0d exp v=0 ov=1 sb=0", v_a, ov_a, sb0.size()); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] e0;
        clr = 1'b1; tick(); clr = 1'b0;
        q_ready = 1'b0;
        send_word(4'h5);
        void'(sb0.pop_front()); void'(sb1.pop_front());
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        q_ready = 1'b1;       // accept 5 on the edge that completes A
        send_bit(1'b1);
        if (sb0.size() == 0) begin checks++; failures++; $display("FAIL b2b_sb empty scoreboard got=0 exp=1"); end
        else begin
            e0 = sb0.pop_front(); void'(sb1.pop_front());
            checks++; if (q_a !== e0 || q_a !== 4'hA) begin failures++; $display("FAIL b2b_word got=%h exp=%h", q_a, e0); end
        end
        checks++; if (v_a !== 1'b1 || ov_a !== 1'b0) begin failures++; $display("FAIL b2b_flags got v=%b ov=%b exp v=1 ov=0", v_a, ov_a); end
        tick();
    endtask

    task automatic test_sync();
        logic [W-1:0] e0, e1;
        send_bit(1'b1); send_bit(1'b1);
        sync = 1'b1; sin_en = 1'b1; sin = 1'b1;   // sync must win over sin_en
        tick();
        sync = 1'b0; sin_en = 1'b0; sin = 1'b0;
        checks++; if (cnt_a !== '0 || v_a !== 1'b0) begin failures++; $display("FAIL sync_cnt got=%0d v=%b exp=0 v=0", cnt_a, v_a); end
        send_word(4'h1);
        if (sb0.size() == 0) begin checks++; failures++; $display("FAIL sync_sb empty scoreboard got=0 exp=1"); end
        else begin
            e0 = sb0.pop_front(); e1 = sb1.pop_front();
            checks++; if (q_a !== e0 || q_a !== 4'h1 || q_b !== e1) begin failures++; $display("FAIL sync_word got=%h/%h exp=%h/%h", q_a, q_b, e0, e1); end
        end
        tick();
    endtask

    task automatic test_clr_midword();
        logic [W-1:0] e0;
        q_ready = 1'b0;
        send_word(4'h7); send_word(4'h2);        // leave q_valid=1, overrun=1
        send_bit(1'b1); send_bit(1'b1);
        clr = 1'b1; sin_en = 1'b1; sin = 1'b1;
        tick();
        clr = 1'b0; sin_en = 1'b0; sin = 1'b0;
        checks++; if (v_a !== 1'b0 || ov_a !== 1'b0 || cnt_a !== '0 || q_a !== '0) begin
            failures++; $display("FAIL clr_mid got q=%h v=%b ov=%b cnt=%0d exp all 0", q_a, v_a, ov_a, cnt_a); end
        q_ready = 1'b1;
        send_word(4'h1);
        if (sb0.size() == 0) begin checks++; failures++; $display("FAIL clr_sb empty scoreboard got=0 exp=1"); end
        else begin
            e0 = sb0.pop_front(); void'(sb1.pop_front());
            checks++; if (q_a !== e0 || q_a !== 4'h1 || v_a !== 1'b1) begin failures++; $display("FAIL clr_word got=%h v=%b exp=%h v=1", q_a, v_a, e0); end
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_enable_gating();
        test_overrun();
        test_back_to_back();
        test_sync();
        test_clr_midword();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
